rtl_subtractor_serial: RTL and testbench



---
 rtl/rtl_subtractor_serial.sv | 120 ++++++++++++
 tb/tb_rtl_subtractor_serial.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rtl_subtractor_serial.sv
// Multi-cycle unsigned subtractor: computes a - b one SLICE-bit slice per clock,
// rippling the borrow between slices through a register.
module rtl_subtractor_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bo
);

  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic             r_brw;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [WIDTH-1:0] w_work_nxt;
  logic             w_brw_nxt;
  logic             w_done_nxt;
  logic [WIDTH-1:0] w_diff_nxt;
  logic             w_bo_nxt;
  logic [SLICE-1:0] w_a_slice;
  logic [SLICE-1:0] w_b_slice;
  logic [SLICE:0]   w_sum;
  logic             w_last;

  // One SLICE-bit adder: a + ~b + carry_in, where carry_in is the inverted borrow.
  always_comb begin
    w_a_slice = r_a[int'(r_cnt)*SLICE +: SLICE];
    w_b_slice = r_b[int'(r_cnt)*SLICE +: SLICE];
    w_sum     = {1'b0, w_a_slice} + {1'b0, ~w_b_slice} + (SLICE+1)'(!r_brw);
    w_last    = (r_cnt == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_work_nxt  = r_work;
    w_brw_nxt   = r_brw;
    w_done_nxt  = 1'b0;
    w_diff_nxt  = diff;
    w_bo_nxt    = bo;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_a_nxt     = a;
          w_b_nxt     = b;
          w_brw_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_work_nxt[int'(r_cnt)*SLICE +: SLICE] = w_sum[SLICE-1:0];
        w_brw_nxt = ~w_sum[SLICE];
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_last) begin
          w_diff_nxt  = w_work_nxt;
          w_bo_nxt    = ~w_sum[SLICE];
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; reset aborts any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_work <= '0;
      r_brw  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bo     <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_a    <= w_a_nxt;
      r_b    <= w_b_nxt;
      r_work <= w_work_nxt;
      r_brw  <= w_brw_nxt;
      busy   <= (w_state_nxt == S_RUN);
      done   <= w_done_nxt;
      diff   <= w_diff_nxt;
      bo     <= w_bo_nxt;
    end
  end

endmodule

// File: tb/tb_rtl_subtractor_serial.sv
// Directed self-checking bench for rtl_subtractor_serial at default parameters.
module tb_rtl_subtractor_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] diff;
  logic        bo;

  int n_tests = 0;
  int n_fail  = 0;

  rtl_subtractor_serial #(.WIDTH(32), .SLICE(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bo    (bo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge (start of the next cycle).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full operation from cycle 0 (start) to cycle 6 (done deasserted).
  task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] ed, input logic eb);
    a = va; b = vb; start = 1'b1;
    step();
    start = 1'b0;
    a = ~va; b = ~vb;
    for (int c = 1; c <= 4; c++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_nodone"}, 32'(done), 32'd0);
      step();
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_lo"}, 32'(busy), 32'd0);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_bo"}, 32'(bo), 32'(eb));
    step();
    check({tag, "_done_lo"}, 32'(done), 32'd0);
    check({tag, "_hold"}, diff, ed);
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", diff, 32'd0);
    check("rst_bo",   32'(bo), 32'd0);
    step();

    run_op("basic",   32'd10,        32'd3,          32'd7,          1'b0);
    run_op("under",   32'd3,         32'd10,         32'hFFFF_FFF9,  1'b1);
    run_op("brw1",    32'h0000_0100, 32'd1,          32'h0000_00FF,  1'b0);
    run_op("brw_all", 32'd0,         32'hFFFF_FFFF,  32'h0000_0001,  1'b1);
    run_op("near",    32'h1234_5678, 32'h1234_5679,  32'hFFFF_FFFF,  1'b1);
    run_op("msb",     32'h8000_0000, 32'h7FFF_FFFF,  32'h0000_0001,  1'b0);

    // Start while busy is ignored; diff keeps the previous result meanwhile.
    a = 32'd10; b = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) begin a = 32'd1; b = 32'd2; start = 1'b1; end
      else start = 1'b0;
      check("ign_diff_hold", diff, 32'd1);
      check("ign_nodone", 32'(done), 32'd0);
      step();
    end
    start = 1'b0;
    check("ign_done", 32'(done), 32'd1);
    check("ign_diff", diff, 32'd7);
    check("ign_bo", 32'(bo), 32'd0);
    step();
    check("ign_idle", 32'(busy), 32'd0);
    step();

    // Back-to-back with start held: results in cycles 5 and 10.
    a = 32'd5; b = 32'd5; start = 1'b1;
    step();
    for (int c = 1; c <= 4; c++) step();
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_diff1", diff, 32'd0);
    check("b2b_bo1", 32'(bo), 32'd0);
    b = 32'd6;
    step();
    for (int c = 6; c <= 9; c++) begin
      check("b2b_gap_done", 32'(done), 32'd0);
      check("b2b_gap_busy", 32'(busy), 32'd1);
      step();
    end
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_diff2", diff, 32'hFFFF_FFFF);
    check("b2b_bo2", 32'(bo), 32'd1);
    start = 1'b0;
    step();
    check("b2b_end_done", 32'(done), 32'd0);
    check("b2b_end_busy", 32'(busy), 32'd0);

    // Reset mid-operation: abort, outputs cleared, no done afterwards.
    run_op("pre_rst", 32'd10, 32'd3, 32'd7, 1'b0);
    a = 32'd100; b = 32'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_diff", diff, 32'd0);
    check("mrst_bo", 32'(bo), 32'd0);
    for (int c = 3; c <= 10; c++) begin
      check("mrst_nodone", 32'(done), 32'd0);
      check("mrst_idle", 32'(busy), 32'd0);
      step();
    end

    // Reset mid-operation, then a fresh start in cycle 4 completes in cycle 9.
    run_op("pre_rst2", 32'd10, 32'd3, 32'd7, 1'b0);
    a = 32'd100; b = 32'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst2_diff", diff, 32'd0);
    step();
    a = 32'd9; b = 32'd4; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 5; c <= 8; c++) begin
      check("mrst2_nodone", 32'(done), 32'd0);
      step();
    end
    check("mrst2_done", 32'(done), 32'd1);
    check("mrst2_diff", diff, 32'd5);
    check("mrst2_bo", 32'(bo), 32'd0);
    step();

    // Reset takes priority over start.
    a = 32'd1; b = 32'd1; start = 1'b1; rst = 1'b1;
    step();
    start = 1'b0; rst = 1'b0;
    check("prio_busy", 32'(busy), 32'd0);
    check("prio_diff", diff, 32'd0);
    step();
    check("prio_still_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
